// File: rtl/dac7611_arbiter.sv
// rtl/dac7611_arbiter.sv - round-robin arbiter sharing one DAC7611 serial DAC among N_REQ requesters
// Optional clear pulse on CLR_6 is built only when DAC7611_CLR_EN is defined.
module dac7611_arbiter #(
    parameter int N_REQ      = 4,
    parameter int LD_CYCLES  = 2,
    parameter int GAP_CYCLES = 2,
    parameter int CLR_CYCLES = 2
) (
    input  logic                clk_X4,
    input  logic                rst,
    input  logic                enable,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ*12-1:0] data,
    output logic [N_REQ-1:0]    ack,
    output logic [N_REQ-1:0]    done,
    output logic                busy,
`ifdef DAC7611_CLR_EN
    input  logic                clr_req,
`endif
    output logic                CLK_3,
    output logic                SDI_4,
    output logic                LD_5,
    output logic                CLR_6
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

`ifdef DAC7611_CLR_EN
    typedef enum logic [2:0] {IDLE, SHIFT, LOAD, GAP, CLEAR} state_t;
`else
    typedef enum logic [2:0] {IDLE, SHIFT, LOAD, GAP} state_t;
`endif

    state_t            state_q, state_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [11:0]       shreg_q, shreg_d;
    logic [PW-1:0]     rr_q, rr_d;
    logic [PW-1:0]     gsel_q, gsel_d;
    logic [N_REQ-1:0]  ack_d, done_d;
    logic              clk3_d, sdi_d, ld_d, clr_d;
    logic              gnt_found;
    logic [PW-1:0]     gnt_idx;
    logic              clr_go;

`ifdef DAC7611_CLR_EN
    logic clr_pend_q, clr_pend_d;
    assign clr_go = clr_pend_q;
`else
    assign clr_go = 1'b0;
`endif

    // First asserted request at or after the round-robin pointer, wrapping.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!gnt_found && req[(int'(rr_q) + k) % N_REQ]) begin
                gnt_found = 1'b1;
                gnt_idx   = PW'((int'(rr_q) + k) % N_REQ);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        rr_d    = rr_q;
        gsel_d  = gsel_q;
        ack_d   = '0;
        done_d  = '0;
`ifdef DAC7611_CLR_EN
        clr_pend_d = clr_pend_q | clr_req;
`endif
        unique case (state_q)
            IDLE: begin
                if (enable) begin
                    if (clr_go) begin
`ifdef DAC7611_CLR_EN
                        state_d    = CLEAR;
                        cnt_d      = '0;
                        clr_pend_d = clr_req;
`endif
                    end else if (gnt_found) begin
                        state_d        = SHIFT;
                        cnt_d          = '0;
                        shreg_d        = data[int'(gnt_idx)*12 +: 12];
                        gsel_d         = gnt_idx;
                        ack_d[gnt_idx] = 1'b1;
                        rr_d           = (gnt_idx == PW'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                    end
                end
            end
            SHIFT: begin
                if (cnt_q == 16'd47) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                    // Advance to the next bit after phase 3 of the current one.
                    if (cnt_q[1:0] == 2'd3) begin
                        shreg_d = {shreg_q[10:0], 1'b0};
                    end
                end
            end
            LOAD: begin
                if (cnt_q == 16'(LD_CYCLES - 1)) begin
                    state_d        = GAP;
                    cnt_d          = '0;
                    done_d[gsel_q] = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            GAP: begin
                if (cnt_q == 16'(GAP_CYCLES - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
`ifdef DAC7611_CLR_EN
            CLEAR: begin
                if (cnt_q == 16'(CLR_CYCLES - 1)) begin
                    state_d = GAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
`endif
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Pin values are derived from the next state so every pin is a plain flop.
    always_comb begin
        clk3_d = 1'b1;
        sdi_d  = 1'b0;
        ld_d   = 1'b1;
        clr_d  = 1'b1;
        case (state_d)
            SHIFT: begin
                clk3_d = cnt_d[1];
                sdi_d  = shreg_d[11];
            end
            LOAD:  ld_d = 1'b0;
`ifdef DAC7611_CLR_EN
            CLEAR: clr_d = 1'b0;
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk_X4) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            rr_q    <= '0;
            gsel_q  <= '0;
            ack     <= '0;
            done    <= '0;
            busy    <= 1'b0;
            CLK_3   <= 1'b1;
            SDI_4   <= 1'b0;
            LD_5    <= 1'b1;
            CLR_6   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            rr_q    <= rr_d;
            gsel_q  <= gsel_d;
            ack     <= ack_d;
            done    <= done_d;
            busy    <= (state_d != IDLE);
            CLK_3   <= clk3_d;
            SDI_4   <= sdi_d;
            LD_5    <= ld_d;
            CLR_6   <= clr_d;
        end
    end

`ifdef DAC7611_CLR_EN
    always_ff @(posedge clk_X4) begin
        if (rst) begin
            clr_pend_q <= 1'b0;
        end else begin
            clr_pend_q <= clr_pend_d;
        end
    end
`endif

endmodule

// File: tb/tb_dac7611_arbiter.sv
// tb/tb_dac7611_arbiter.sv - self-checking bench for dac7611_arbiter (default build, clear disabled)
module tb_dac7611_arbiter;
    localparam int N = 4;

    logic            clk_X4 = 1'b0;
    logic            rst    = 1'b1;
    logic            enable = 1'b0;
    logic [N-1:0]    req    = '0;
    logic [N*12-1:0] data   = '0;
    logic [N-1:0]    ack, done;
    logic            busy, CLK_3, SDI_4, LD_5, CLR_6;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int model_rr = 0;

    always #5 clk_X4 = ~clk_X4;

    dac7611_arbiter #(.N_REQ(N), .LD_CYCLES(2), .GAP_CYCLES(2), .CLR_CYCLES(2)) dut (
        .clk_X4(clk_X4), .rst(rst), .enable(enable), .req(req), .data(data),
        .ack(ack), .done(done), .busy(busy),
        .CLK_3(CLK_3), .SDI_4(SDI_4), .LD_5(LD_5), .CLR_6(CLR_6)
    );

    // Pin-level monitor: rebuilds each frame from CLK_3 rising edges and timestamps pulses.
    int          ack_cyc[$], ack_val[$], done_cyc[$], done_val[$];
    int          frame_word[$], frame_bits[$], frame_ld[$];
    logic        prev_clk3 = 1'b1, prev_ld = 1'b1;
    logic [11:0] acc = '0;
    int          nbits = 0, nld = 0, clr_low = 0;

    always @(negedge clk_X4) begin
        cyc++;
        if (!CLR_6) clr_low++;
        if (rst) begin
            nbits = 0; nld = 0; acc = '0; prev_clk3 = 1'b1; prev_ld = 1'b1;
        end else begin
            if (ack != 0) begin ack_cyc.push_back(cyc); ack_val.push_back(int'(ack)); end
            if (done != 0) begin done_cyc.push_back(cyc); done_val.push_back(int'(done)); end
            if (!prev_clk3 && CLK_3) begin acc = {acc[10:0], SDI_4}; nbits++; end
            if (!LD_5) nld++;
            if (!prev_ld && LD_5) begin
                frame_word.push_back(int'(acc)); frame_bits.push_back(nbits); frame_ld.push_back(nld);
                nbits = 0; nld = 0;
            end
            prev_clk3 = CLK_3;
            prev_ld   = LD_5;
        end
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(negedge clk_X4); #1; end
    endtask

    function automatic int qsize(input int sel);
        return (sel == 0) ? ack_cyc.size() : done_cyc.size();
    endfunction

    task automatic wait_ev(input string nm, input int sel, input int bound, output int c, output int v);
        int n;
        n = 0; c = -1; v = 0;
        while (qsize(sel) == 0 && n < bound) begin tick(1); n++; end
        checks++;
        if (qsize(sel) == 0) begin
            errors++;
            $display("FAIL %s: no pulse within %0d cycles", nm, bound);
        end else if (sel == 0) begin
            c = ack_cyc.pop_front(); v = ack_val.pop_front();
        end else begin
            c = done_cyc.pop_front(); v = done_val.pop_front();
        end
    endtask

    // Reference arbitration: lowest index at or after the pointer, wrapping.
    function automatic int pick(input logic [N-1:0] m);
        for (int k = 0; k < N; k++) if (m[(model_rr + k) % N]) return (model_rr + k) % N;
        return -1;
    endfunction

    task automatic check_frame(input string nm, input logic [11:0] code);
        chk({nm, " frame present"}, frame_word.size(), 1);
        if (frame_word.size() > 0) begin
            chk({nm, " shifted word"}, frame_word.pop_front(), code);
            chk({nm, " bit count"}, frame_bits.pop_front(), 12);
            chk({nm, " LD low cycles"}, frame_ld.pop_front(), 2);
        end
    endtask

    task automatic do_write(input string nm, input logic [N-1:0] mask, output int ack_c);
        int g, c, v, dc, dv;
        logic [11:0] code;
        g = pick(mask);
        code = data[12*g +: 12];
        req = mask;
        wait_ev({nm, " ack"}, 0, 200, c, v);
        req = '0;
        ack_c = c;
        chk({nm, " ack index"}, v, 1 << g);
        model_rr = (g + 1) % N;
        chk({nm, " busy"}, busy, 1);
        wait_ev({nm, " done"}, 1, 100, dc, dv);
        chk({nm, " done index"}, dv, 1 << g);
        chk({nm, " ack-to-done"}, dc - c, 50);
        check_frame(nm, code);
    endtask

    typedef struct {
        logic [N-1:0]    req;
        logic [N*12-1:0] data;
        int              exp_idx;
        logic [11:0]     exp_word;
    } vec_t;
    vec_t tbl[5];

    initial begin
        int t0, c, v, dc, dv, prev_c;
        for (int r = 0; r < 5; r++) begin
            tbl[r].req  = 4'b1111;
            tbl[r].data = {12'h444, 12'h333, 12'h222, 12'h111};
        end
        tbl[0].exp_idx = 0; tbl[0].exp_word = 12'h111;
        tbl[1].exp_idx = 1; tbl[1].exp_word = 12'h222;
        tbl[2].exp_idx = 2; tbl[2].exp_word = 12'h333;
        tbl[3].exp_idx = 3; tbl[3].exp_word = 12'h444;
        tbl[4].exp_idx = 0; tbl[4].exp_word = 12'h111;

        tick(3);
        chk("reset CLK_3", CLK_3, 1);
        chk("reset SDI_4", SDI_4, 0);
        chk("reset LD_5", LD_5, 1);
        chk("reset CLR_6", CLR_6, 1);
        chk("reset ack", ack, 0);
        chk("reset done", done, 0);
        chk("reset busy", busy, 0);
        rst = 1'b0;
        model_rr = 0;
        tick(2);

        // Single write of 0xA5C from requester 0.
        enable = 1'b1;
        data[11:0] = 12'hA5C;
        t0 = cyc;
        do_write("single", 4'b0001, c);
        chk("single ack latency", c - t0, 1);
        tick(4);

        // Round-robin with all requests held, from a fresh pointer.
        rst = 1'b1; tick(1); rst = 1'b0; model_rr = 0;
        prev_c = 0;
        for (int r = 0; r < 5; r++) begin
            req  = tbl[r].req;
            data = tbl[r].data;
            wait_ev("rr ack", 0, 200, c, v);
            chk("rr ack index", v, 1 << tbl[r].exp_idx);
            if (r > 0) chk("rr frame spacing", c - prev_c, 53);
            prev_c = c;
            wait_ev("rr done", 1, 100, dc, dv);
            chk("rr done index", dv, 1 << tbl[r].exp_idx);
            check_frame("rr", tbl[r].exp_word);
        end
        req = '0;
        model_rr = 1;
        tick(4);

        // Reset at shift cycle 20 aborts the frame and rewinds the pointer.
        req = 4'b0010;
        wait_ev("abort ack", 0, 200, c, v);
        req = '0;
        chk("abort ack index", v, 4'b0010);
        tick(20);
        rst = 1'b1;
        tick(1);
        chk("abort CLK_3", CLK_3, 1);
        chk("abort SDI_4", SDI_4, 0);
        chk("abort LD_5", LD_5, 1);
        chk("abort busy", busy, 0);
        rst = 1'b0;
        model_rr = 0;
        tick(60);
        chk("abort no done", done_cyc.size(), 0);
        chk("abort no frame", frame_word.size(), 0);
        do_write("post-reset pointer", 4'b0110, c);
        tick(3);
        do_write("post-reset req2", 4'b0100, c);
        tick(3);

        // enable low blocks grants but never an in-flight frame.
        enable = 1'b0;
        req = 4'b0010;
        tick(100);
        chk("disabled no ack", ack_cyc.size(), 0);
        chk("disabled busy", busy, 0);
        enable = 1'b1;
        t0 = cyc;
        wait_ev("enable ack", 0, 10, c, v);
        req = '0;
        chk("enable ack latency", c - t0, 1);
        chk("enable ack index", v, 1 << pick(4'b0010));
        model_rr = (pick(4'b0010) + 1) % N;
        tick(10);
        enable = 1'b0;
        wait_ev("enable-drop done", 1, 100, dc, dv);
        chk("enable-drop done index", dv, 4'b0010);
        chk("enable-drop latency", dc - c, 50);
        check_frame("enable-drop", data[23:12]);
        enable = 1'b1;
        tick(3);

        // Randomized traffic against the reference arbitration.
        for (int it = 0; it < 24; it++) begin
            for (int i = 0; i < N; i++) data[12*i +: 12] = 12'($urandom);
            do_write("random", 4'($urandom_range(1, 15)), c);
            tick($urandom_range(0, 5));
        end

        chk("CLR_6 never asserted", clr_low, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
